data_mem_sized: RTL and testbench

//  Parametrised synchronous data memory for the single-cycle MIPS16 datapath. Supersedes the fixed word-only store RAM.

---
 rtl/data_mem_sized_if.sv | 38 +++
 rtl/data_mem_sized.sv | 147 ++++++++++++++
 tb/tb_data_mem_sized.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_sized_if.sv
// Request/response bundle between the datapath and data_mem_sized; trace signals exist only with STORE_TRACE_EN.
interface data_mem_sized_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
);
  logic                  mem_write_en;
  logic                  mem_read_en;
  logic                  byte_sl;
  logic                  load_signed;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  ready;
  logic                  misaligned;
`ifdef STORE_TRACE_EN
  logic [ADDR_WIDTH-1:0] last_store_addr;
  logic [DATA_WIDTH-1:0] last_store_data;
  logic [15:0]           store_count;

  modport master (
    output mem_write_en, mem_read_en, byte_sl, load_signed, addr, write_data,
    input  read_data, ready, misaligned, last_store_addr, last_store_data, store_count
  );
  modport slave (
    input  mem_write_en, mem_read_en, byte_sl, load_signed, addr, write_data,
    output read_data, ready, misaligned, last_store_addr, last_store_data, store_count
  );
`else
  modport master (
    output mem_write_en, mem_read_en, byte_sl, load_signed, addr, write_data,
    input  read_data, ready, misaligned
  );
  modport slave (
    input  mem_write_en, mem_read_en, byte_sl, load_signed, addr, write_data,
    output read_data, ready, misaligned
  );
`endif
endinterface

// File: rtl/data_mem_sized.sv
// Byte-lane data memory: 1-cycle registered loads with same-word store forwarding, zero-fill after reset.
// ready is low for DEPTH cycles while clearing and requests are dropped; STORE_TRACE_EN adds store trace outputs.
module data_mem_sized #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int OFF_BITS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  data_mem_sized_if.slave   bus
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = ADDR_WIDTH - OFF_BITS;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      clr_idx_q, clr_idx_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  misaligned_q, misaligned_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  idle;
  logic                  store_acc;
  logic                  load_acc;
  logic [IDX_W-1:0]      req_idx;
  logic [OFF_BITS-1:0]   lane;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            rd_byte;
  logic                  rd_sign;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdat;

  always_comb begin
    idle      = (state_q == S_IDLE);
    store_acc = idle && bus.mem_write_en;
    load_acc  = idle && bus.mem_read_en;
    req_idx   = bus.addr[ADDR_WIDTH-1:OFF_BITS];
    lane      = bus.addr[OFF_BITS-1:0];
    old_word  = mem_q[req_idx];

    merged_word = old_word;
    if (bus.byte_sl) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane == OFF_BITS'(l)) merged_word[8*l +: 8] = bus.write_data[7:0];
      end
    end else begin
      merged_word = bus.write_data;
    end

    // Reads and writes share one address, so a same-cycle store always hits the loaded word.
    rd_word = store_acc ? merged_word : old_word;
    rd_byte = 8'h00;
    for (int l = 0; l < LANES; l++) begin
      if (lane == OFF_BITS'(l)) rd_byte = rd_word[8*l +: 8];
    end
    rd_sign = bus.load_signed && rd_byte[7];
  end

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    read_data_d  = read_data_q;
    misaligned_d = 1'b0;
    mem_we       = 1'b0;
    mem_widx     = req_idx;
    mem_wdat     = merged_word;
    case (state_q)
      S_CLEAR: begin
        mem_we    = !reset;
        mem_widx  = clr_idx_q;
        mem_wdat  = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        mem_we = store_acc && !reset;
        if (load_acc) begin
          if (bus.byte_sl) read_data_d = {{(DATA_WIDTH-8){rd_sign}}, rd_byte};
          else             read_data_d = rd_word;
        end
        misaligned_d = (store_acc || load_acc) && !bus.byte_sl && (lane != '0);
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_idx_q    <= '0;
      read_data_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      read_data_q  <= read_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdat;
  end

  assign bus.read_data  = read_data_q;
  assign bus.ready      = (state_q == S_IDLE);
  assign bus.misaligned = misaligned_q;

`ifdef STORE_TRACE_EN
  logic [ADDR_WIDTH-1:0] last_store_addr_q, last_store_addr_d;
  logic [DATA_WIDTH-1:0] last_store_data_q, last_store_data_d;
  logic [15:0]           store_count_q, store_count_d;

  always_comb begin
    last_store_addr_d = last_store_addr_q;
    last_store_data_d = last_store_data_q;
    store_count_d     = store_count_q;
    if (store_acc) begin
      last_store_addr_d = bus.addr;
      last_store_data_d = merged_word;
      if (store_count_q != 16'hFFFF) store_count_d = store_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_store_addr_q <= '0;
      last_store_data_q <= '0;
      store_count_q     <= '0;
    end else begin
      last_store_addr_q <= last_store_addr_d;
      last_store_data_q <= last_store_data_d;
      store_count_q     <= store_count_d;
    end
  end

  assign bus.last_store_addr = last_store_addr_q;
  assign bus.last_store_data = last_store_data_q;
  assign bus.store_count     = store_count_q;
`endif
endmodule

// File: tb/tb_data_mem_sized.sv
// Directed checks of data_mem_sized: clear timing, word/byte stores and loads, forwarding, misaligned, reset restart.
module tb_data_mem_sized;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  data_mem_sized_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) bus_if ();

  data_mem_sized #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .OFF_BITS(1)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock with the given request; enables drop right after the edge.
  task automatic op(input logic we, input logic re, input logic bsl, input logic lsg,
                    input logic [8:0] a, input logic [15:0] wd);
    bus_if.mem_write_en = we;
    bus_if.mem_read_en  = re;
    bus_if.byte_sl      = bsl;
    bus_if.load_signed  = lsg;
    bus_if.addr         = a;
    bus_if.write_data   = wd;
    @(posedge clk);
    #1;
    bus_if.mem_write_en = 1'b0;
    bus_if.mem_read_en  = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus_if.ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    logic bad;
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus_if.mem_write_en = 1'b0;
    bus_if.mem_read_en  = 1'b0;
    bus_if.byte_sl      = 1'b0;
    bus_if.load_signed  = 1'b0;
    bus_if.addr         = '0;
    bus_if.write_data   = '0;

    // Reset and initial clear
    @(posedge clk);
    #1;
    chk("rst_ready", bus_if.ready, 0);
    chk("rst_read_data", bus_if.read_data, 0);
    chk("rst_misaligned", bus_if.misaligned, 0);
    rst = 1'b0;
    wait_ready(n);
    chk("clear_cycles", n, 256);
    op(0, 1, 0, 0, 9'd100, 16'h0);
    chk("cleared_word", bus_if.read_data, 16'h0000);

    // Word store then load
    op(1, 0, 0, 0, 9'd4, 16'h1234);
`ifdef STORE_TRACE_EN
    chk("trace_addr", bus_if.last_store_addr, 9'd4);
    chk("trace_data", bus_if.last_store_data, 16'h1234);
    chk("trace_count1", bus_if.store_count, 1);
`endif
    op(0, 1, 0, 0, 9'd4, 16'h0);
    chk("lw4", bus_if.read_data, 16'h1234);
    chk("lw4_aligned", bus_if.misaligned, 0);

    // Byte store into upper lane, byte loads
    op(1, 0, 1, 0, 9'd5, 16'h00AB);
    op(0, 1, 0, 0, 9'd4, 16'h0);
    chk("lw4_after_sb", bus_if.read_data, 16'hAB34);
    op(0, 1, 1, 1, 9'd5, 16'h0);
    chk("lb5_signed", bus_if.read_data, 16'hFFAB);
    chk("lb5_no_misaligned", bus_if.misaligned, 0);
    op(0, 1, 1, 0, 9'd5, 16'h0);
    chk("lb5_unsigned", bus_if.read_data, 16'h00AB);
    op(0, 1, 1, 1, 9'd4, 16'h0);
    chk("lb4_signed_pos", bus_if.read_data, 16'h0034);

    // Same-cycle store and load forwarding
    op(1, 1, 0, 0, 9'd8, 16'hBEEF);
    chk("fwd_word", bus_if.read_data, 16'hBEEF);
    op(0, 0, 0, 0, 9'd0, 16'h0);
    chk("read_hold", bus_if.read_data, 16'hBEEF);
`ifdef STORE_TRACE_EN
    chk("trace_count3", bus_if.store_count, 3);
    chk("trace_data_fwd", bus_if.last_store_data, 16'hBEEF);
`endif
    op(1, 1, 1, 1, 9'd9, 16'h1288);
    chk("fwd_byte", bus_if.read_data, 16'hFF88);
    op(0, 1, 0, 0, 9'd8, 16'h0);
    chk("lw8_merged", bus_if.read_data, 16'h88EF);

    // Misaligned word accesses
    op(1, 0, 0, 0, 9'd7, 16'h5555);
    chk("sw7_misaligned", bus_if.misaligned, 1);
    op(0, 0, 0, 0, 9'd7, 16'h0);
    chk("misaligned_pulse_end", bus_if.misaligned, 0);
    op(0, 1, 0, 0, 9'd6, 16'h0);
    chk("lw6", bus_if.read_data, 16'h5555);
    chk("lw6_aligned", bus_if.misaligned, 0);
    op(0, 1, 1, 0, 9'd7, 16'h0);
    chk("lb7", bus_if.read_data, 16'h0055);
    chk("lb7_no_misaligned", bus_if.misaligned, 0);
    op(0, 1, 0, 0, 9'd9, 16'h0);
    chk("lw9_data", bus_if.read_data, 16'h88EF);
    chk("lw9_misaligned", bus_if.misaligned, 1);
    op(1, 0, 1, 0, 9'd6, 16'h12FF);
    op(0, 1, 0, 0, 9'd6, 16'h0);
    chk("lw6_low_lane", bus_if.read_data, 16'h55FF);

    // Top of address space
    op(1, 0, 0, 0, 9'd510, 16'hCAFE);
    op(0, 1, 0, 0, 9'd510, 16'h0);
    chk("lw510", bus_if.read_data, 16'hCAFE);
    op(0, 1, 0, 0, 9'd0, 16'h0);
    chk("lw0_no_alias", bus_if.read_data, 16'h0000);

    // Reset mid-clear with requests held active
    rst = 1'b1;
    op(0, 0, 0, 0, 9'd0, 16'h0);
    rst = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    chk("mid_clear_ready", bus_if.ready, 0);
    rst = 1'b1;
    bus_if.mem_write_en = 1'b1;
    bus_if.mem_read_en  = 1'b1;
    bus_if.byte_sl      = 1'b0;
    bus_if.addr         = 9'd3;
    bus_if.write_data   = 16'h9999;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    bad = 1'b0;
    while (!bus_if.ready && n < 2000) begin
      if (bus_if.read_data !== 16'h0 || bus_if.misaligned !== 1'b0) bad = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    bus_if.mem_write_en = 1'b0;
    bus_if.mem_read_en  = 1'b0;
    chk("restart_clear_cycles", n, 256);
    chk("clear_outputs_quiet", bad, 0);
`ifdef STORE_TRACE_EN
    chk("trace_count_cleared", bus_if.store_count, 0);
`endif
    op(1, 0, 0, 0, 9'd20, 16'h4321);
    op(0, 1, 0, 0, 9'd20, 16'h0);
    chk("lw20_post_clear", bus_if.read_data, 16'h4321);
    op(0, 1, 0, 0, 9'd2, 16'h0);
    chk("clear_store_ignored", bus_if.read_data, 16'h0000);
    op(0, 1, 0, 0, 9'd4, 16'h0);
    chk("rezeroed_4", bus_if.read_data, 16'h0000);
    op(0, 1, 0, 0, 9'd510, 16'h0);
    chk("rezeroed_510", bus_if.read_data, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end
endmodule
